// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle shifter with valid/ready handshakes.
//
// The block accepts an operand, an op code and a shift amount. It shifts by up
// to STEP bits per clock and then holds the result until the consumer takes it.
// Op codes: 00 none, 01 LSL, 10 LSR, 11 ASR (the MSB is copied in).
// Amounts of WIDTH or more are clamped to WIDTH.
//
// Parameters: WIDTH (operand bits, >=2), AMT_W (amount bits), STEP (1..WIDTH)
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid / in_ready   operand handshake; in_ready is high only in IDLE
//   shift, amt, in        op code, amount and operand, sampled on accept
//   out_valid / out_ready result handshake; out is stable while out_valid
//   out                   result register
//   busy                  high in SHIFT and in DONE
//   carry                 last bit shifted out (only when SHIFTER_CARRY_EN)
//
// Build option: define SHIFTER_CARRY_EN to add the carry output and its logic.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// SHIFT | shifting out by min(STEP,count) each cycle
// DONE  | result presented, out_valid=1 until out_ready
module shifter_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       shift,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
`ifdef SHIFTER_CARRY_EN
  ,
  output logic             carry
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic [1:0]       op, op_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] amt_clamp;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] shifted;

  // The amount is compared in 32 bits so that the clamp also works when AMT_W
  // is wider or narrower than the counter.
  always_comb begin
    amt_clamp = CNT_W'(WIDTH);
    if (32'(amt) < 32'(WIDTH)) amt_clamp = CNT_W'(amt);
  end

  // Bits moved this cycle: the full step, or whatever is left.
  assign n = (count > CNT_W'(STEP)) ? CNT_W'(STEP) : count;

  always_comb begin
    shifted = out;
    case (op)
      2'b01:   shifted = out << n;
      2'b10:   shifted = out >> n;
      2'b11:   shifted = $unsigned($signed(out) >>> n);
      default: shifted = out;
    endcase
  end

`ifdef SHIFTER_CARRY_EN
  logic             carry_nxt;
  logic             bit_out;
  logic [WIDTH-1:0] probe;

  // The last bit that leaves the register: out[WIDTH-n] for a left shift and
  // out[n-1] for a right shift. It is picked by shifting that bit into position 0.
  always_comb begin
    probe = '0;
    case (op)
      2'b01:        probe = out >> (CNT_W'(WIDTH) - n);
      2'b10, 2'b11: probe = out >> (n - CNT_W'(1));
      default:      probe = '0;
    endcase
    bit_out = probe[0];
  end
`endif

  always_comb begin
    state_nxt = state;
    out_nxt   = out;
    op_nxt    = op;
    count_nxt = count;
`ifdef SHIFTER_CARRY_EN
    carry_nxt = carry;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          out_nxt   = in;
          op_nxt    = shift;
          count_nxt = amt_clamp;
`ifdef SHIFTER_CARRY_EN
          carry_nxt = 1'b0;
`endif
          if (shift == 2'b00 || amt_clamp == '0) state_nxt = DONE;
          else                                   state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        out_nxt   = shifted;
        count_nxt = count - n;
`ifdef SHIFTER_CARRY_EN
        carry_nxt = bit_out;
`endif
        if (count == n) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      out   <= '0;
      op    <= 2'b00;
      count <= '0;
`ifdef SHIFTER_CARRY_EN
      carry <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      out   <= out_nxt;
      op    <= op_nxt;
      count <= count_nxt;
`ifdef SHIFTER_CARRY_EN
      carry <= carry_nxt;
`endif
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
